// File: rtl/pe_dma_pkg.sv
// Shared types for the PE DMA sequencer: FSM states, transfer direction
// and an index-width helper used by the arbiter and the top.
package pe_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WAIT_SPACE,
    ISSUE,
    XFER,
    DONE,
    ERROR
  } dma_state_t;

  typedef enum logic {
    RD,
    WR
  } txn_dir_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_rr_arbiter.sv
// Round-robin arbiter: searches the pending vector starting at `start`
// and returns the first hit as one-hot grant plus binary index.
module pe_rr_arbiter
  import pe_dma_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(start) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(start) + i) % N);
        gnt[(int'(start) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_dma_sequencer.sv
// PE DMA sequencer: bursts per-channel requests onto one AXI master.
// Define PE_DMA_PERF_CNT_EN to add busy/stall performance counters.
module pe_dma_sequencer
  import pe_dma_pkg::*;
#(
  parameter int NUM_RD_CH   = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS_WIDTH = 12,
  parameter int MAX_BURST   = 16,
  localparam int NCH = NUM_RD_CH + 1,
  localparam int LW  = $clog2(MAX_BURST) + 1
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [NCH-1:0]                      REQ,
  input  logic [NCH-1:0][ADDR_WIDTH-1:0]      REQ_BASE_ADDR,
  input  logic [NCH-1:0][WORDS_WIDTH-1:0]     REQ_WORDS,
  input  logic [NCH-1:0]                      CH_SPACE_OK,
  input  logic                                ABORT,
  input  logic                                CLEAR_ERR,
  output logic [NUM_RD_CH-1:0]                CH_WR_CMD,
  output logic                                OUT_FIFO_RD_CMD,
  output logic [NCH-1:0]                      CH_DONE,
  output logic                                BUSY,
  output logic                                ERR,
  output logic [ADDR_WIDTH-1:0]               M_TARGET_SLAVE_BASE_ADDR,
  output logic                                M_TXN_WRITE,
  output logic [LW-1:0]                       M_TXN_LEN,
  output logic                                INIT_AXI_TXN,
  input  logic                                M_AXI_RVALID_RREADY,
  input  logic                                M_AXI_WVALID_WREADY,
  input  logic                                TXN_DONE,
  input  logic                                AXI_ERROR
`ifdef PE_DMA_PERF_CNT_EN
  ,
  output logic [31:0]                         PERF_BUSY_CYC,
  output logic [31:0]                         PERF_STALL_CYC
`endif
);

  localparam int CW  = idx_w(NCH);
  localparam int BPW = DATA_WIDTH / 8;

  dma_state_t state, state_n;

  logic [NCH-1:0]                  pending, accept, zero_done;
  logic [NCH-1:0]                  gnt, act_oh;
  logic [NCH-1:0][ADDR_WIDTH-1:0]  base, offset;
  logic [NCH-1:0][WORDS_WIDTH-1:0] remain;
  logic [CW-1:0]                   act, ptr, gnt_idx;
  logic                            gnt_any, aborting;
  logic                            ch_active, last_burst;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [LW-1:0]                   len_q, burst_len;
  txn_dir_t                        dir_q;

  pe_rr_arbiter #(.N(NCH)) u_arb (
    .req   (pending),
    .start (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign act_oh     = NCH'(1) << act;
  assign ch_active  = state inside {WAIT_SPACE, ISSUE, XFER, DONE};
  assign last_burst = remain[act] == WORDS_WIDTH'(len_q);
  assign burst_len  = (remain[act] > WORDS_WIDTH'(MAX_BURST))
                    ? LW'(MAX_BURST) : remain[act][LW-1:0];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      accept[c] = REQ[c] && !pending[c]
               && !(ch_active && act == CW'(c));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (|pending && !ABORT) state_n = ARB;
      ARB:        state_n = (ABORT || !gnt_any) ? IDLE : WAIT_SPACE;
      WAIT_SPACE: begin
        if (ABORT)                   state_n = IDLE;
        else if (CH_SPACE_OK[act])   state_n = ISSUE;
      end
      ISSUE:      state_n = XFER;
      XFER: begin
        // error outranks a completion reported in the same cycle
        if (AXI_ERROR)                  state_n = ERROR;
        else if (TXN_DONE) begin
          if (aborting || ABORT)        state_n = IDLE;
          else if (last_burst)          state_n = DONE;
          else                          state_n = WAIT_SPACE;
        end
      end
      DONE:       state_n = IDLE;
      ERROR:      if (CLEAR_ERR) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending   <= '0;
      zero_done <= '0;
      base      <= '0;
      offset    <= '0;
      remain    <= '0;
      act       <= '0;
      ptr       <= '0;
      aborting  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      dir_q     <= RD;
    end else begin
      if (state == ARB && gnt_any) begin
        act <= gnt_idx;
        ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == WAIT_SPACE && state_n == ISSUE) begin
        addr_q <= base[act] + offset[act];
        len_q  <= burst_len;
        dir_q  <= (act == CW'(NUM_RD_CH)) ? WR : RD;
      end
      if (state == XFER && TXN_DONE && !AXI_ERROR) begin
        offset[act] <= offset[act]
                     + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(BPW);
        remain[act] <= remain[act] - WORDS_WIDTH'(len_q);
      end
      if (state_n == IDLE)
        aborting <= 1'b0;
      else if (ABORT && state inside {ISSUE, XFER})
        aborting <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        zero_done[c] <= accept[c] && REQ_WORDS[c] == '0;
        if (accept[c] && REQ_WORDS[c] != '0) begin
          base[c]   <= REQ_BASE_ADDR[c];
          remain[c] <= REQ_WORDS[c];
          offset[c] <= '0;
        end
        if (ABORT)
          pending[c] <= 1'b0;
        else if (act_oh[c] && (state == DONE
                 || (state == XFER && AXI_ERROR)))
          pending[c] <= 1'b0;
        else if (accept[c] && REQ_WORDS[c] != '0)
          pending[c] <= 1'b1;
      end
    end
  end

  assign BUSY            = state != IDLE;
  assign ERR             = state == ERROR;
  assign INIT_AXI_TXN    = state == ISSUE;
  assign M_TARGET_SLAVE_BASE_ADDR = addr_q;
  assign M_TXN_LEN       = len_q;
  assign M_TXN_WRITE     = dir_q == WR;
  assign CH_WR_CMD       = (state == XFER && dir_q == RD && M_AXI_RVALID_RREADY)
                         ? act_oh[NUM_RD_CH-1:0] : '0;
  assign OUT_FIFO_RD_CMD = state == XFER && dir_q == WR && M_AXI_WVALID_WREADY;
  assign CH_DONE         = zero_done | ((state == DONE) ? act_oh : '0);

`ifdef PE_DMA_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERF_BUSY_CYC  <= '0;
      PERF_STALL_CYC <= '0;
    end else begin
      if (BUSY && PERF_BUSY_CYC != '1)
        PERF_BUSY_CYC <= PERF_BUSY_CYC + 1'b1;
      if (state == WAIT_SPACE && PERF_STALL_CYC != '1)
        PERF_STALL_CYC <= PERF_STALL_CYC + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_dma_sequencer.sv
// Directed bench for pe_dma_sequencer with a small scripted AXI responder.
// Expected addresses, lengths and grant order are worked out by hand.
module tb_pe_dma_sequencer;

  localparam int NR = 3;
  localparam int NC = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [NC-1:0]    REQ;
  logic [NC-1:0][31:0] REQ_BASE_ADDR;
  logic [NC-1:0][11:0] REQ_WORDS;
  logic [NC-1:0]    CH_SPACE_OK;
  logic             ABORT, CLEAR_ERR;
  logic [NR-1:0]    CH_WR_CMD;
  logic             OUT_FIFO_RD_CMD;
  logic [NC-1:0]    CH_DONE;
  logic             BUSY, ERR;
  logic [31:0]      M_TARGET_SLAVE_BASE_ADDR;
  logic             M_TXN_WRITE;
  logic [4:0]       M_TXN_LEN;
  logic             INIT_AXI_TXN;
  logic             M_AXI_RVALID_RREADY, M_AXI_WVALID_WREADY;
  logic             TXN_DONE, AXI_ERROR;

  int total = 0;
  int bad   = 0;

  pe_dma_sequencer dut (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .REQ                      (REQ),
    .REQ_BASE_ADDR            (REQ_BASE_ADDR),
    .REQ_WORDS                (REQ_WORDS),
    .CH_SPACE_OK              (CH_SPACE_OK),
    .ABORT                    (ABORT),
    .CLEAR_ERR                (CLEAR_ERR),
    .CH_WR_CMD                (CH_WR_CMD),
    .OUT_FIFO_RD_CMD          (OUT_FIFO_RD_CMD),
    .CH_DONE                  (CH_DONE),
    .BUSY                     (BUSY),
    .ERR                      (ERR),
    .M_TARGET_SLAVE_BASE_ADDR (M_TARGET_SLAVE_BASE_ADDR),
    .M_TXN_WRITE              (M_TXN_WRITE),
    .M_TXN_LEN                (M_TXN_LEN),
    .INIT_AXI_TXN             (INIT_AXI_TXN),
    .M_AXI_RVALID_RREADY      (M_AXI_RVALID_RREADY),
    .M_AXI_WVALID_WREADY      (M_AXI_WVALID_WREADY),
    .TXN_DONE                 (TXN_DONE),
    .AXI_ERROR                (AXI_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!INIT_AXI_TXN && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_init"}, 64'(INIT_AXI_TXN), 64'd1);
  endtask

  // beats for the burst in XFER, then TXN_DONE; returns in the following state
  task automatic beats(input string tag, input int len, input int ch);
    int good = 0;
    logic [NR-1:0] oh;
    oh = NR'(1 << ch);
    for (int b = 0; b < len; b++) begin
      if (ch == NR) M_AXI_WVALID_WREADY = 1'b1;
      else          M_AXI_RVALID_RREADY = 1'b1;
      #1;
      if (ch == NR) begin
        if (OUT_FIFO_RD_CMD === 1'b1 && CH_WR_CMD === '0) good++;
      end else begin
        if (CH_WR_CMD === oh && OUT_FIFO_RD_CMD === 1'b0) good++;
      end
      step();
    end
    M_AXI_RVALID_RREADY = 1'b0;
    M_AXI_WVALID_WREADY = 1'b0;
    chk({tag, "_strobes"}, 64'(good), 64'(len));
    TXN_DONE = 1'b1;
    step();
    TXN_DONE = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [31:0] addr,
                     input int len, input int ch);
    wait_init(tag);
    chk({tag, "_addr"}, 64'(M_TARGET_SLAVE_BASE_ADDR), 64'(addr));
    chk({tag, "_len"},  64'(M_TXN_LEN), 64'(len));
    chk({tag, "_wr"},   64'(M_TXN_WRITE), 64'(ch == NR));
    step();
    chk({tag, "_pulse"}, 64'(INIT_AXI_TXN), 64'd0);
    beats(tag, len, ch);
  endtask

  initial begin
    logic seen;
    RESET = 1'b1;
    REQ = '0;
    REQ_BASE_ADDR = '0;
    REQ_WORDS = '0;
    CH_SPACE_OK = '1;
    ABORT = 1'b0;
    CLEAR_ERR = 1'b0;
    M_AXI_RVALID_RREADY = 1'b0;
    M_AXI_WVALID_WREADY = 1'b0;
    TXN_DONE = 1'b0;
    AXI_ERROR = 1'b0;
    step();
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_err",  64'(ERR), 64'd0);
    chk("rst_init", 64'(INIT_AXI_TXN), 64'd0);
    chk("rst_addr", 64'(M_TARGET_SLAVE_BASE_ADDR), 64'd0);
    chk("rst_len",  64'(M_TXN_LEN), 64'd0);
    chk("rst_done", 64'(CH_DONE), 64'd0);
    RESET = 1'b0;
    step();

    // 40 words from 0x1000 -> 16 + 16 + 8
    REQ_BASE_ADDR[0] = 32'h1000;
    REQ_WORDS[0] = 12'd40;
    REQ = 4'b0001;
    step();
    REQ = '0;
    txn("t1a", 32'h1000, 16, 0);
    chk("t1a_nodone", 64'(CH_DONE), 64'd0);
    txn("t1b", 32'h1040, 16, 0);
    txn("t1c", 32'h1080, 8, 0);
    chk("t1_done", 64'(CH_DONE), 64'h1);
    step();
    chk("t1_done_1cyc", 64'(CH_DONE), 64'h0);
    chk("t1_idle", 64'(BUSY), 64'd0);

    // all four channels at once, fresh pointer
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int c = 0; c < NC; c++) begin
      REQ_BASE_ADDR[c] = 32'h2000 + 32'(c) * 32'h100;
      REQ_WORDS[c] = 12'd4;
    end
    REQ = 4'b1111;
    step();
    REQ = '0;
    for (int c = 0; c < NC; c++) begin
      txn($sformatf("t2_%0d", c), 32'h2000 + 32'(c) * 32'h100, 4, c);
      chk($sformatf("t2_done%0d", c), 64'(CH_DONE), 64'(1 << c));
    end
    // round restarts at 0: ch1 first, then ch2 ahead of a later ch0
    REQ = 4'b0110;
    step();
    REQ = '0;
    txn("t2_rr1", 32'h2100, 4, 1);
    chk("t2_rr1_done", 64'(CH_DONE), 64'h2);
    REQ = 4'b0001;
    step();
    REQ = '0;
    txn("t2_rr2", 32'h2200, 4, 2);
    chk("t2_rr2_done", 64'(CH_DONE), 64'h4);
    txn("t2_rr0", 32'h2000, 4, 0);
    chk("t2_rr0_done", 64'(CH_DONE), 64'h1);
    step();

    // space withheld on ch1 for 20 cycles
    CH_SPACE_OK = 4'b1101;
    REQ = 4'b0010;
    step();
    REQ = '0;
    seen = 1'b0;
    repeat (20) begin
      if (INIT_AXI_TXN) seen = 1'b1;
      step();
    end
    chk("t3_no_init", 64'(seen), 64'd0);
    chk("t3_busy", 64'(BUSY), 64'd1);
    CH_SPACE_OK = '1;
    step();
    chk("t3_init_next", 64'(INIT_AXI_TXN), 64'd1);
    txn("t3", 32'h2100, 4, 1);
    chk("t3_done", 64'(CH_DONE), 64'h2);
    step();

    // error together with TXN_DONE; pointer is at 2 so ch2 goes first
    REQ = 4'b0101;
    step();
    REQ = '0;
    wait_init("t4");
    chk("t4_addr", 64'(M_TARGET_SLAVE_BASE_ADDR), 64'h2200);
    step();
    AXI_ERROR = 1'b1;
    TXN_DONE = 1'b1;
    step();
    AXI_ERROR = 1'b0;
    TXN_DONE = 1'b0;
    chk("t4_err", 64'(ERR), 64'd1);
    chk("t4_nodone", 64'(CH_DONE), 64'd0);
    chk("t4_busy", 64'(BUSY), 64'd1);
    step();
    step();
    chk("t4_sticky", 64'(ERR), 64'd1);
    chk("t4_hold_init", 64'(INIT_AXI_TXN), 64'd0);
    CLEAR_ERR = 1'b1;
    step();
    CLEAR_ERR = 1'b0;
    chk("t4_clr_err", 64'(ERR), 64'd0);
    chk("t4_clr_idle", 64'(BUSY), 64'd0);
    txn("t4b", 32'h2000, 4, 0);
    chk("t4b_done", 64'(CH_DONE), 64'h1);
    step();

    // abort mid-transfer with two others pending
    REQ = 4'b0111;
    step();
    REQ = '0;
    wait_init("t5");
    chk("t5_addr", 64'(M_TARGET_SLAVE_BASE_ADDR), 64'h2100);
    step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    beats("t5", 4, 1);
    chk("t5_idle", 64'(BUSY), 64'd0);
    chk("t5_nodone", 64'(CH_DONE), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      if (INIT_AXI_TXN || BUSY) seen = 1'b1;
      step();
    end
    chk("t5_no_pending", 64'(seen), 64'd0);
    REQ_WORDS[3] = 12'd0;
    REQ = 4'b1000;
    step();
    REQ = '0;
    chk("t5_zero_done", 64'(CH_DONE), 64'h8);
    chk("t5_zero_idle", 64'(BUSY), 64'd0);
    step();
    chk("t5_zero_1cyc", 64'(CH_DONE), 64'h0);
    chk("t5_zero_notxn", 64'(BUSY | INIT_AXI_TXN), 64'd0);

    // reset during a read burst, then stray beats in IDLE
    REQ_WORDS[0] = 12'd8;
    REQ = 4'b0001;
    step();
    REQ = '0;
    wait_init("t6");
    step();
    M_AXI_RVALID_RREADY = 1'b1;
    #1;
    chk("t6_strobe", 64'(CH_WR_CMD), 64'h1);
    RESET = 1'b1;
    step();
    chk("t6_busy", 64'(BUSY), 64'd0);
    chk("t6_wr_cmd", 64'(CH_WR_CMD), 64'd0);
    chk("t6_addr", 64'(M_TARGET_SLAVE_BASE_ADDR), 64'd0);
    chk("t6_len", 64'(M_TXN_LEN), 64'd0);
    chk("t6_init", 64'(INIT_AXI_TXN), 64'd0);
    RESET = 1'b0;
    step();
    M_AXI_WVALID_WREADY = 1'b1;
    #1;
    chk("t6_stray_rd", 64'(CH_WR_CMD), 64'd0);
    chk("t6_stray_wr", 64'(OUT_FIFO_RD_CMD), 64'd0);
    M_AXI_RVALID_RREADY = 1'b0;
    M_AXI_WVALID_WREADY = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
